// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master instruction/data memory arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising instruction fetches and data loads/stores onto
// one strobe/ack memory port, absorbing the memory's one-cycle read-data lag.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_adr_i,
  input  logic          i_stb_i,
  output logic [DW-1:0] i_dat_o,
  output logic          i_ack_o,
  input  logic [AW-1:0] d_adr_i,
  input  logic [DW-1:0] d_dat_i,
  input  logic          d_we_i,
  input  logic          d_stb_i,
  output logic [DW-1:0] d_dat_o,
  output logic          d_ack_o,
  output logic [AW:0]   s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic          bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_state_nxt;
  logic          r_gnt, w_gnt_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW:0]   r_s_adr, w_s_adr_nxt;
  logic [DW-1:0] r_s_dat, w_s_dat_nxt;
  logic          r_s_we, w_s_we_nxt;
  logic          r_s_stb, w_s_stb_nxt;
  logic [DW-1:0] r_i_dat, w_i_dat_nxt;
  logic          r_i_ack, w_i_ack_nxt;
  logic [DW-1:0] r_d_dat, w_d_dat_nxt;
  logic          r_d_ack, w_d_ack_nxt;
  logic          r_bus_err, w_bus_err_nxt;

  logic          w_i_req;
  logic          w_d_req;
  logic          w_sel;
  logic [CW-1:0] w_cnt_inc;

  // A master's strobe is still high in its own ack cycle; mask it so it is not re-granted.
  assign w_i_req   = i_stb_i & ~r_i_ack;
  assign w_d_req   = d_stb_i & ~r_d_ack;
  assign w_sel     = (w_i_req && w_d_req) ? ((r_last == GNT_I) ? GNT_D : GNT_I)
                                          : (w_d_req ? GNT_D : GNT_I);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_s_adr_nxt   = r_s_adr;
    w_s_dat_nxt   = r_s_dat;
    w_s_we_nxt    = r_s_we;
    w_s_stb_nxt   = r_s_stb;
    w_i_dat_nxt   = r_i_dat;
    w_i_ack_nxt   = 1'b0;
    w_d_dat_nxt   = r_d_dat;
    w_d_ack_nxt   = 1'b0;
    w_bus_err_nxt = r_bus_err;

    case (r_state)
      ST_IDLE: begin
        // Hold off while the memory still shows an ack from a previous access.
        if (!s_ack_i && (w_i_req || w_d_req)) begin
          w_gnt_nxt   = w_sel;
          w_s_adr_nxt = (w_sel == GNT_D) ? {1'b0, d_adr_i} : {1'b0, i_adr_i};
          w_s_dat_nxt = (w_sel == GNT_D) ? d_dat_i : '0;
          w_s_we_nxt  = (w_sel == GNT_D) & d_we_i;
          w_s_stb_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (s_ack_i) begin
          w_s_stb_nxt = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_s_stb_nxt   = 1'b0;
          w_bus_err_nxt = 1'b1;
          if (r_gnt == GNT_D) begin
            w_d_ack_nxt = 1'b1;
            w_d_dat_nxt = '0;
          end else begin
            w_i_ack_nxt = 1'b1;
            w_i_dat_nxt = '0;
          end
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      ST_RESP: begin
        if (r_gnt == GNT_D) begin
          w_d_ack_nxt = 1'b1;
          if (!r_s_we) w_d_dat_nxt = s_dat_i;
        end else begin
          w_i_ack_nxt = 1'b1;
          w_i_dat_nxt = s_dat_i;
        end
        w_last_nxt  = r_gnt;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= GNT_I;
      r_last    <= GNT_I;
      r_cnt     <= '0;
      r_s_adr   <= '0;
      r_s_dat   <= '0;
      r_s_we    <= 1'b0;
      r_s_stb   <= 1'b0;
      r_i_dat   <= '0;
      r_i_ack   <= 1'b0;
      r_d_dat   <= '0;
      r_d_ack   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_s_adr   <= w_s_adr_nxt;
      r_s_dat   <= w_s_dat_nxt;
      r_s_we    <= w_s_we_nxt;
      r_s_stb   <= w_s_stb_nxt;
      r_i_dat   <= w_i_dat_nxt;
      r_i_ack   <= w_i_ack_nxt;
      r_d_dat   <= w_d_dat_nxt;
      r_d_ack   <= w_d_ack_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  assign i_dat_o = r_i_dat;
  assign i_ack_o = r_i_ack;
  assign d_dat_o = r_d_dat;
  assign d_ack_o = r_d_ack;
  assign s_adr_o = r_s_adr;
  assign s_dat_o = r_s_dat;
  assign s_we_o  = r_s_we;
  assign s_stb_o = r_s_stb;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences
// and randomized two-master traffic against a transaction-level memory model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_adr_i = '0;
  logic          i_stb_i = 1'b0;
  logic [DW-1:0] i_dat_o;
  logic          i_ack_o;
  logic [AW-1:0] d_adr_i = '0;
  logic [DW-1:0] d_dat_i = '0;
  logic          d_we_i  = 1'b0;
  logic          d_stb_i = 1'b0;
  logic [DW-1:0] d_dat_o;
  logic          d_ack_o;
  logic [AW:0]   s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_we_o;
  logic          s_stb_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic          bus_err;

  // Memory model: registered ack one cycle after strobe, read data one cycle after ack.
  logic          mem_ack       = 1'b0;
  logic          mem_en        = 1'b1;
  logic          mem_init_done = 1'b0;
  logic [DW-1:0] mem_rdata     = '0;
  logic [DW-1:0] mem [0:63];

  int n_checks = 0;
  int n_err    = 0;

  assign s_ack_i = mem_ack;
  assign s_dat_i = mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr_i), .i_stb_i(i_stb_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .bus_err(bus_err)
  );

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 64; k++) mem[6'(k)] <= 32'h1000_0000 + 32'(k);
      mem[4] <= 32'h1234_5678;
      mem_init_done <= 1'b1;
    end else if (mem_ack && s_stb_o) begin
      if (s_we_o) mem[s_adr_o[7:2]] <= s_dat_o;
      else        mem_rdata <= mem[s_adr_o[7:2]];
    end
    mem_ack <= s_stb_o & ~mem_ack & mem_en;
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_stb_i = 1'b0;
    d_stb_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string p);
    check({p, ".i_dat"}, 64'(i_dat_o), 64'd0);
    check({p, ".d_dat"}, 64'(d_dat_o), 64'd0);
    check({p, ".s_adr"}, 64'(s_adr_o), 64'd0);
    check({p, ".s_dat"}, 64'(s_dat_o), 64'd0);
    check({p, ".flags"}, 64'({i_ack_o, d_ack_o, s_we_o, s_stb_o, bus_err}), 64'd0);
  endtask

  // One transaction from an idle bus; returns what was observed up to and including the ack.
  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] adr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lat, output int stb_cyc, output logic [32:0] seen_adr,
                        output logic seen_we, output int other_acks);
    bit done = 0;
    rdata = '0; lat = 0; stb_cyc = 0; seen_adr = '0; seen_we = 1'b0; other_acks = 0;
    if (is_d) begin
      d_adr_i = adr; d_dat_i = wdata; d_we_i = we; d_stb_i = 1'b1;
    end else begin
      i_adr_i = adr; i_stb_i = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      lat = c;
      if (s_stb_o) begin
        stb_cyc++;
        seen_adr = s_adr_o;
        seen_we  = s_we_o;
      end
      if (is_d ? i_ack_o : d_ack_o) other_acks++;
      if (is_d ? d_ack_o : i_ack_o) begin
        rdata = is_d ? d_dat_o : i_dat_o;
        done  = 1;
        break;
      end
    end
    i_stb_i = 1'b0;
    d_stb_i = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL txn_ack_wait: no ack within 40 cycles for adr 0x%0h", adr);
    end
    tick();
  endtask

  logic [31:0] t_dat;
  int          t_lat, t_stb, t_oth;
  logic [32:0] t_adr;
  logic        t_we;
  int          ack_port [4];
  int          ack_cyc  [4];
  logic [31:0] ack_dat  [4];
  int          n_ack, both_cnt, grants, overlap, other_cnt;
  logic        prev_stb;
  logic [31:0] model_mem [0:63];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 0, 32'h10, 32'h0,         32'h1234_5678};
    vecs[1] = '{1, 1, 32'h20, 32'hCAFE_F00D, 32'h0};
    vecs[2] = '{1, 0, 32'h20, 32'h0,         32'hCAFE_F00D};
    vecs[3] = '{1, 1, 32'h20, 32'h0BAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{0, 0, 32'h20, 32'h0,         32'h0BAD_BEEF};
    vecs[5] = '{1, 0, 32'h3C, 32'h0,         32'h1000_000F};
    vecs[6] = '{0, 0, 32'h00, 32'h0,         32'h1000_0000};

    do_reset();
    check_zero("reset");

    // Isolated transactions: 4-cycle latency, 2 strobe cycles, exact address/we.
    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].is_d, vecs[v].we, vecs[v].adr, vecs[v].wdata, t_dat, t_lat, t_stb, t_adr, t_we, t_oth);
      check($sformatf("vec%0d.dat", v),   64'(t_dat), 64'(vecs[v].exp_dat));
      check($sformatf("vec%0d.lat", v),   64'(t_lat), 64'd4);
      check($sformatf("vec%0d.stb", v),   64'(t_stb), 64'd2);
      check($sformatf("vec%0d.s_adr", v), 64'(t_adr), {31'd0, 1'b0, vecs[v].adr});
      check($sformatf("vec%0d.s_we", v),  64'(t_we),  64'(vecs[v].we));
      check($sformatf("vec%0d.other", v), 64'(t_oth), 64'd0);
    end

    // Simultaneous requests from reset: D wins first, then strict alternation.
    do_reset();
    i_adr_i = 32'h10; d_adr_i = 32'h20; d_we_i = 1'b0;
    i_stb_i = 1'b1;   d_stb_i = 1'b1;
    n_ack = 0; both_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (i_ack_o && d_ack_o) both_cnt++;
      if ((i_ack_o || d_ack_o) && n_ack < 4) begin
        ack_port[n_ack] = d_ack_o ? 1 : 0;
        ack_cyc[n_ack]  = c;
        ack_dat[n_ack]  = d_ack_o ? d_dat_o : i_dat_o;
        n_ack++;
        if (n_ack == 4) begin
          i_stb_i = 1'b0;
          d_stb_i = 1'b0;
        end
      end
    end
    check("sim.n_ack", 64'(n_ack), 64'd4);
    check("sim.both", 64'(both_cnt), 64'd0);
    for (int k = 0; k < n_ack; k++) begin
      check($sformatf("sim.port%0d", k), 64'(ack_port[k]), 64'((k % 2 == 0) ? 1 : 0));
      check($sformatf("sim.cyc%0d", k),  64'(ack_cyc[k]),  64'(4 * (k + 1)));
      check($sformatf("sim.dat%0d", k),  64'(ack_dat[k]),
            (k % 2 == 0) ? 64'h0BAD_BEEF : 64'h1234_5678);
    end

    // Back-to-back fetches with strobe held through the ack.
    i_adr_i = 32'h0C; i_stb_i = 1'b1;
    prev_stb = s_stb_o; grants = 0; n_ack = 0; overlap = 0; other_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (s_stb_o && !prev_stb) grants++;
      prev_stb = s_stb_o;
      if (i_ack_o && s_stb_o) overlap++;
      if (d_ack_o) other_cnt++;
      if (i_ack_o) begin
        if (n_ack < 3) ack_cyc[n_ack] = c;
        n_ack++;
        if (n_ack == 3) i_stb_i = 1'b0;
      end
    end
    check("b2b.grants", 64'(grants), 64'd3);
    check("b2b.acks", 64'(n_ack), 64'd3);
    check("b2b.overlap", 64'(overlap), 64'd0);
    check("b2b.d_ack", 64'(other_cnt), 64'd0);
    check("b2b.dat", 64'(i_dat_o), 64'h1000_0003);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b.cyc%0d", k), 64'(ack_cyc[k]), 64'(4 + 5 * k));

    // Strobe dropped mid-transaction: the access still completes and acks.
    d_adr_i = 32'h3C; d_we_i = 1'b0; d_stb_i = 1'b1;
    tick(); tick();
    d_stb_i = 1'b0;
    t_lat = 0;
    for (int c = 3; c <= 20; c++) begin
      tick();
      if (d_ack_o && t_lat == 0) begin
        t_lat = c;
        t_dat = d_dat_o;
      end
    end
    check("drop.lat", 64'(t_lat), 64'd4);
    check("drop.dat", 64'(t_dat), 64'h1000_000F);

    // Memory never acks: abort after TIMEOUT cycles of strobe, sticky error.
    mem_en = 1'b0;
    do_txn(0, 0, 32'h10, 32'h0, t_dat, t_lat, t_stb, t_adr, t_we, t_oth);
    check("to.stb_cycles", 64'(t_stb), 64'(TO));
    check("to.lat", 64'(t_lat), 64'(TO + 1));
    check("to.dat", 64'(t_dat), 64'd0);
    check("to.bus_err", 64'(bus_err), 64'd1);
    mem_en = 1'b1;
    do_txn(0, 0, 32'h10, 32'h0, t_dat, t_lat, t_stb, t_adr, t_we, t_oth);
    check("to.after_dat", 64'(t_dat), 64'h1234_5678);
    check("to.after_lat", 64'(t_lat), 64'd4);
    check("to.sticky", 64'(bus_err), 64'd1);

    // Reset during REQ; the memory's stale ack must block the first new grant.
    i_adr_i = 32'h04; i_stb_i = 1'b1;
    tick();
    check("rstreq.stb", 64'(s_stb_o), 64'd1);
    rst_n = 1'b0;
    tick();
    check_zero("rstreq");
    rst_n = 1'b1;
    tick();
    check("rstreq.hold_stb", 64'(s_stb_o), 64'd0);
    check("rstreq.no_ack", 64'(i_ack_o), 64'd0);
    tick();
    check("rstreq.grant", 64'(s_stb_o), 64'd1);
    t_lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (i_ack_o) begin
        t_lat = c;
        t_dat = i_dat_o;
        break;
      end
    end
    i_stb_i = 1'b0;
    check("rstreq.lat", 64'(t_lat), 64'd3);
    check("rstreq.dat", 64'(t_dat), 64'h1000_0001);
    tick();

    // Randomized two-master traffic against a transaction-level memory model.
    for (int k = 0; k < 64; k++) model_mem[6'(k)] = mem[6'(k)];
    begin
      bit          i_act = 0, d_act = 0, d_st = 0;
      int          i_age = 0, d_age = 0;
      logic [5:0]  i_idx = '0, d_idx = '0;
      logic [31:0] d_wd = '0, last_d = '0;
      for (int c = 0; c < 3000; c++) begin
        tick();
        if (i_act) i_age++;
        if (d_act) d_age++;
        if (i_ack_o && d_ack_o) check("rnd.both_ack", 64'd1, 64'd0);
        if (i_ack_o) begin
          check("rnd.i_ack_expected", 64'(i_act), 64'd1);
          if (i_act) begin
            check("rnd.i_dat", 64'(i_dat_o), 64'(model_mem[i_idx]));
            n_checks++;
            if (i_age < 4 || i_age > 8) begin
              n_err++;
              $display("FAIL rnd.i_lat: latency %0d, required 4..8", i_age);
            end
            i_act = 0; i_stb_i = 1'b0;
          end
        end
        if (d_ack_o) begin
          check("rnd.d_ack_expected", 64'(d_act), 64'd1);
          if (d_act) begin
            if (d_st) begin
              model_mem[d_idx] = d_wd;
              check("rnd.d_dat_store", 64'(d_dat_o), 64'(last_d));
            end else begin
              check("rnd.d_dat_load", 64'(d_dat_o), 64'(model_mem[d_idx]));
              last_d = model_mem[d_idx];
            end
            n_checks++;
            if (d_age < 4 || d_age > 8) begin
              n_err++;
              $display("FAIL rnd.d_lat: latency %0d, required 4..8", d_age);
            end
            d_act = 0; d_stb_i = 1'b0;
          end
        end
        if (c < 2960) begin
          if (!i_act && !i_ack_o && $urandom_range(0, 1) == 1) begin
            i_idx = 6'($urandom_range(0, 15));
            i_adr_i = {24'd0, i_idx, 2'b00};
            i_stb_i = 1'b1; i_act = 1; i_age = 0;
          end
          if (!d_act && !d_ack_o && $urandom_range(0, 1) == 1) begin
            d_idx = 6'($urandom_range(0, 15));
            d_st  = 1'($urandom_range(0, 1));
            d_wd  = $urandom;
            d_adr_i = {24'd0, d_idx, 2'b00};
            d_dat_i = d_wd; d_we_i = d_st;
            d_stb_i = 1'b1; d_act = 1; d_age = 0;
          end
        end
      end
      check("rnd.drained", 64'({i_act, d_act}), 64'd0);
      check("rnd.no_err", 64'(bus_err), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sitting directly upstream of the shared instruction/data memory. It accepts instruction-fetch requests and CPU data load/store requests on two Wishbone-classic style slave ports. It serialises them onto the single strobe/acknowledge memory port and returns read data and acknowledges to the originating master. It also hides the memory's one-cycle read-data lag behind the memory's registered acknowledge.

## Interface
- `AW`, 32: master address width; the memory address is `AW+1` bits, zero-extended.
- `DW`, 32: data width.
- `TIMEOUT`, 15: maximum number of cycles to wait for the memory acknowledge before aborting.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_adr_i`  in  AW  instruction fetch address (read only).
- `i_stb_i`  in  1  instruction request; held stable until `i_ack_o`.
- `i_dat_o`  out  DW  fetched word.
- `i_ack_o`  out  1  one-cycle completion pulse.
- `d_adr_i`  in  AW  data address.
- `d_dat_i`  in  DW  store data.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_stb_i`  in  1  data request; held stable until `d_ack_o`.
- `d_dat_o`  out  DW  load data.
- `d_ack_o`  out  1  one-cycle completion pulse.
- `s_adr_o`  out  AW+1  memory address.
- `s_dat_o`  out  DW  memory write data.
- `s_we_o`  out  1  memory write enable.
- `s_stb_o`  out  1  memory strobe.
- `s_dat_i`  in  DW  memory read data; valid the cycle after `s_ack_i`.
- `s_ack_i`  in  1  memory acknowledge.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, RESP.
- **Reset.** IDLE. All outputs 0. Last-grant flag = instruction, so the data port wins the first tie.
- **IDLE.**
  - A master's strobe is ignored in the cycle its own ack is high.
  - A new grant is issued only when `s_ack_i`=0.
  - One master requesting: grant it.
  - Both requesting: grant the master not granted last (round-robin).
  - On grant: register address, write data and write enable (instruction port forces we=0). Set `s_stb_o`=1, clear the timeout counter, go to REQ.
- **REQ.** `s_stb_o` is held.
  - `s_ack_i`=1: the memory commits on this edge. Drop `s_stb_o` and go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT`: drop `s_stb_o`, set `bus_err`, and return ack with data 0 to the granted master. The transaction is aborted; go to IDLE.
- **RESP.** `s_stb_o`=0 and `s_dat_i` is valid.
  - Latch `s_dat_i` into the granted master's `*_dat_o` (loads and fetches only; stores leave `d_dat_o` unchanged).
  - Pulse that master's ack and update the last-grant flag. Go to IDLE.
- `*_dat_o` holds its value until the next completion on the same port.
- `bus_err` clears only on reset.
- A store never drives `i_dat_o` or `i_ack_o`. A fetch never drives the `d_*` outputs.

## Timing
- Request high in cycle 0 (IDLE):
  - cycle 1: `s_stb_o`=1
  - cycle 2: `s_ack_i`=1 from the memory
  - cycle 3: RESP
  - cycle 4: master ack=1 with data valid
- Request-to-ack latency is 4 cycles. Sustained throughput is one access per 4 cycles.
- Between two grants, `s_stb_o` stays low for at least the RESP cycle and the ack cycle. This guarantees the memory's stale ack has cleared.
- Reset mid-transaction: outputs are cleared on the reset edge and no ack is issued. After release, the first grant waits until `s_ack_i`=0.
- Master strobe dropped before ack (protocol violation): the transaction still completes and the ack is still pulsed.

## Structure
- Shared package holds:
  - state encoding (IDLE/REQ/RESP);
  - grant-select constants (GNT_I, GNT_D);
  - default `TIMEOUT`.
- No sub-module: the 2-way round-robin picker and the timeout counter are inline.

## Test plan
- Fetch only: `i_adr_i`=0x0000_0010 with memory word 4 = 0x1234_5678 → `s_adr_o`=0x0_0000_0010, `s_we_o`=0. `i_ack_o` is high in cycle 4 with `i_dat_o`=0x1234_5678; `d_ack_o` stays 0.
- Store then load: store 0xCAFE_F00D to 0x20, then load 0x20 → `s_we_o`=1 during the first grant, and `d_dat_o`=0xCAFE_F00D on the second `d_ack_o`.
- Simultaneous requests from reset: both strobes held high → grant order D, I, D, I. Acks are 4 cycles apart and never both high in the same cycle.
- Back-to-back fetches with the strobe held through the ack → exactly one access per ack and no duplicate access in the ack cycle.
- Memory model never acks → `s_stb_o` drops after 15 cycles in REQ, master ack has data 0, `bus_err`=1 until reset.
- `rst_n` low in REQ → next cycle all outputs are 0. After release with the memory ack still high for one cycle, no grant is issued until `s_ack_i`=0.
